// File: rtl/fixed_point_bcd_converter.sv
// Signed fixed-point to sign + BCD converter: double-dabble integer digits, then x10 fraction digits.
// Latency INT_BITS+FRAC_DIGITS cycles from start to done; start is ignored while busy (no other backpressure).
module fixed_point_bcd_converter #(
  parameter int INT_BITS    = 12,
  parameter int FRAC_BITS   = 4,
  parameter int INT_DIGITS  = 4,
  parameter int FRAC_DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INT_BITS+FRAC_BITS-1:0]   val,
  output logic                            busy,
  output logic                            done,
  output logic                            neg,
  output logic                            ovf,
  output logic [4*INT_DIGITS-1:0]         bcd_int,
  output logic [4*FRAC_DIGITS-1:0]        bcd_frac
);

  localparam int W          = INT_BITS + FRAC_BITS;
  // ceil(INT_BITS/3) digits always cover 2^INT_BITS-1, so the accumulator never wraps.
  localparam int ACC_DIGITS = INT_BITS / 3 + 1;
  localparam int EXT_DIGITS = (ACC_DIGITS > INT_DIGITS) ? ACC_DIGITS : INT_DIGITS;
  localparam int CNT_MAX    = (INT_BITS > FRAC_DIGITS) ? INT_BITS : FRAC_DIGITS;
  localparam int CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_INT, S_FRAC, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      sign_q, sign_d;
  logic [INT_BITS-1:0]       ish_q, ish_d;
  logic [FRAC_BITS-1:0]      frac_q, frac_d;
  logic [4*ACC_DIGITS-1:0]   acc_q, acc_d;
  logic [4*FRAC_DIGITS-1:0]  fdig_q, fdig_d;
  logic                      neg_q, neg_d;
  logic                      ovf_q, ovf_d;
  logic [4*INT_DIGITS-1:0]   bint_q, bint_d;
  logic [4*FRAC_DIGITS-1:0]  bfrac_q, bfrac_d;

  logic [W-1:0]              mag;
  logic [4*ACC_DIGITS-1:0]   acc_adj;
  logic [4*EXT_DIGITS-1:0]   acc_ext;
  logic [FRAC_BITS+3:0]      prod;
  logic                      int_ovf;

  // Two's-complement negate in W bits leaves 2^(W-1) intact as an unsigned magnitude.
  assign mag     = val[W-1] ? (~val + W'(1)) : val;
  assign prod    = {4'b0000, frac_q} * (FRAC_BITS+4)'(10);
  assign acc_ext = (4*EXT_DIGITS)'(acc_q);

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    int_ovf = 1'b0;
    for (int i = INT_DIGITS; i < EXT_DIGITS; i++) begin
      if (acc_ext[4*i +: 4] != 4'd0) int_ovf = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    ish_d   = ish_q;
    frac_d  = frac_q;
    acc_d   = acc_q;
    fdig_d  = fdig_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    bint_d  = bint_q;
    bfrac_d = bfrac_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = val[W-1];
          ish_d   = mag[W-1:FRAC_BITS];
          frac_d  = mag[FRAC_BITS-1:0];
          acc_d   = '0;
          fdig_d  = '0;
          cnt_d   = CW'(INT_BITS);
          state_d = S_INT;
        end
      end
      S_INT: begin
        acc_d = {acc_adj[4*ACC_DIGITS-2:0], ish_q[INT_BITS-1]};
        ish_d = ish_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          cnt_d   = CW'(FRAC_DIGITS);
          state_d = S_FRAC;
        end
      end
      S_FRAC: begin
        frac_d = prod[FRAC_BITS-1:0];
        fdig_d = (fdig_q << 4) | (4*FRAC_DIGITS)'(prod[FRAC_BITS+3:FRAC_BITS]);
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          // Publish on the edge into DONE, using the digit produced this cycle.
          ovf_d   = int_ovf;
          bint_d  = int_ovf ? {INT_DIGITS{4'h9}} : acc_ext[4*INT_DIGITS-1:0];
          bfrac_d = int_ovf ? {FRAC_DIGITS{4'h9}} : fdig_d;
          neg_d   = sign_q & (int_ovf | (|bint_d) | (|bfrac_d));
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ish_q   <= '0;
      frac_q  <= '0;
      acc_q   <= '0;
      fdig_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bint_q  <= '0;
      bfrac_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ish_q   <= ish_d;
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      fdig_q  <= fdig_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      bint_q  <= bint_d;
      bfrac_q <= bfrac_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign neg      = neg_q;
  assign ovf      = ovf_q;
  assign bcd_int  = bint_q;
  assign bcd_frac = bfrac_q;

endmodule

// File: doc/fixed_point_bcd_converter.md
FIXED_POINT_BCD_CONVERTER -- requirements
Module: fixed_point_bcd_converter

Interface
REQ-001 Parameter INT_BITS, default 12: integer bits of the signed two's-complement input, sign bit included.
REQ-002 Parameter FRAC_BITS, default 4: fraction bits of the input (LSB weight 2^-FRAC_BITS).
REQ-003 Parameter INT_DIGITS, default 4: BCD digits produced for the integer part.
REQ-004 Parameter FRAC_DIGITS, default 4: BCD digits produced for the fraction part.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: conversion request, sampled only in IDLE.
REQ-008 Port val, input, W = INT_BITS+FRAC_BITS: signed fixed-point operand, sampled with start.
REQ-009 Port busy, output, 1: high while a conversion is in flight.
REQ-010 Port done, output, 1: one-cycle pulse marking that new results are valid.
REQ-011 Port neg, output, 1: displayed sign of the last result.
REQ-012 Port ovf, output, 1: the last integer magnitude did not fit in INT_DIGITS.
REQ-013 Port bcd_int, output, 4*INT_DIGITS: integer digits, most-significant digit in the top nibble.
REQ-014 Port bcd_frac, output, 4*FRAC_DIGITS: fraction digits, tenths digit in the top nibble.

Function
REQ-015 The FSM SHALL have states IDLE, INT, FRAC and DONE, and only the transitions listed in REQ-016 to REQ-019.
REQ-016 IDLE with start=1: capture |val| into a W-bit unsigned magnitude register, capture the sign, load counter=INT_BITS, and go to INT.
REQ-017 INT: one shift-add-3 (double-dabble) step per cycle on the integer magnitude bits; after INT_BITS cycles, go to FRAC.
REQ-018 FRAC: each cycle, frac_reg*10; the bits above FRAC_BITS form the next digit (tenths first) and the low FRAC_BITS are kept; after FRAC_DIGITS cycles, go to DONE.
REQ-019 DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-020 Latency: start sampled at edge k gives done=1 in the cycle after edge k+INT_BITS+FRAC_DIGITS (16 cycles at defaults).
REQ-021 busy SHALL be 1 from edge k up to and including the DONE cycle, and 0 in IDLE.
REQ-022 start while not in IDLE SHALL be ignored; val changes after capture SHALL not affect the result.
REQ-023 neg, ovf, bcd_int and bcd_frac SHALL update only on the edge entering DONE and hold until the next DONE or reset.
REQ-024 Magnitude SHALL be exact for the most negative input: 2^(W-1), with no wrap.
REQ-025 Fraction digits SHALL be truncated, never rounded; exact whenever FRAC_DIGITS >= FRAC_BITS.
REQ-026 Overflow condition: integer magnitude >= 10^INT_DIGITS.
REQ-027 On overflow: ovf=1 and every digit of bcd_int and bcd_frac = 9; neg still reflects the input sign.
REQ-028 neg SHALL be 0 when ovf=0 and all published digits are zero (no "-0").
REQ-029 The internal BCD accumulator SHALL be wide enough for all INT_BITS, so overflow is detected rather than wrapped.
REQ-030 done SHALL be high together with updated outputs in the same cycle, never a cycle before them.

Reset
REQ-031 rst=1 at an edge forces IDLE, busy=0, done=0, neg=0, ovf=0, bcd_int=0 and bcd_frac=0, regardless of state.
REQ-032 rst asserted mid-conversion aborts it; no done pulse follows.
REQ-033 rst and start high together: rst wins and no conversion starts.
REQ-034 After rst deasserts, the first start is accepted in the following IDLE cycle.

Verification (defaults unless stated)
REQ-035 val=16'h0010, start pulse -> done 16 cycles later; bcd_int=16'h0001, bcd_frac=16'h0000, neg=0, ovf=0.
REQ-036 val=16'hFFFF -> neg=1, bcd_int=16'h0000, bcd_frac=16'h0625; val=16'h8000 -> neg=1, bcd_int=16'h2048, bcd_frac=0.
REQ-037 val=16'h7FFF -> bcd_int=16'h2047, bcd_frac=16'h9375, neg=0; val=16'h0000 -> all zero, neg=0.
REQ-038 INT_DIGITS=3, val=16'h3E80 (1000.0) -> ovf=1, bcd_int=12'h999, bcd_frac=16'h9999; FRAC_DIGITS=1, val=16'hFFFF -> bcd_frac=4'h0, neg=0.
REQ-039 Pulse start again at cycle 5 of a conversion with a different val -> ignored; single done with the first result; busy continuous.
REQ-040 rst at cycle 8 of a conversion -> outputs zero next cycle, no done; a new start then gives a correct result after 16 cycles.
